// File: rtl/bayer_quad_demosaic.sv
// Raw 12-bit Bayer stream to half-resolution RGB: each 2x2 quad yields one pixel.
// The top row of every quad pair is kept in a split even/odd-column line buffer.
module bayer_quad_demosaic #(
  parameter int LINE_WIDTH  = 1280,
  parameter int BAYER_ORDER = 0
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [11:0] iData,
  input  logic        iDval,
  input  logic [15:0] iX_Cont,
  input  logic [15:0] iY_Cont,
  input  logic        iFval,
  output logic [11:0] oRed,
  output logic [11:0] oGreen,
  output logic [11:0] oBlue,
  output logic        oDval,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont
);
  localparam int STAGES = 2;
  localparam int PAIRS  = (LINE_WIDTH + 1) / 2;
  localparam int AW     = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [16:0] LW17 = 17'(LINE_WIDTH);

  typedef struct packed {
    logic [11:0] tl, tr, bl, br;
    logic [15:0] x, y;
  } quad_t;

  typedef struct packed {
    logic [11:0] r, g, b;
    logic [15:0] x, y;
  } rgb_t;

  logic [11:0]     lb_even [PAIRS];
  logic [11:0]     lb_odd  [PAIRS];
  logic [11:0]     hold;
  logic [STAGES:0] vld_pipe;
  quad_t           s1;
  rgb_t            s2, s2_next;

  logic          accept, wr_even, wr_odd, hold_en, complete;
  logic [AW-1:0] pair_addr;

  assign accept    = iDval & iFval & ({1'b0, iX_Cont} < LW17);
  assign pair_addr = iX_Cont[AW:1];
  assign wr_even   = accept & ~iY_Cont[0] & ~iX_Cont[0];
  assign wr_odd    = accept & ~iY_Cont[0] &  iX_Cont[0];
  assign hold_en   = accept &  iY_Cont[0] & ~iX_Cont[0];
  assign complete  = accept &  iY_Cont[0] &  iX_Cont[0];

  // Line buffer carries no reset; stale contents feed partial quads by design.
  always_ff @(posedge iClk) begin
    if (wr_even) lb_even[pair_addr] <= iData;
    if (wr_odd)  lb_odd[pair_addr]  <= iData;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      hold     <= '0;
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (!iFval)       hold <= '0;
      else if (hold_en) hold <= iData;
      // Only new launches are gated by iFval; quads already in flight drain.
      vld_pipe <= {vld_pipe[STAGES-1:0], complete};
      if (complete) begin
        s1.tl <= lb_even[pair_addr];
        s1.tr <= lb_odd[pair_addr];
        s1.bl <= hold;
        s1.br <= iData;
        s1.x  <= {1'b0, iX_Cont[15:1]};
        s1.y  <= {1'b0, iY_Cont[15:1]};
      end
      if (vld_pipe[0]) s2 <= s2_next;
    end
  end

  logic [11:0] g1, g2;
  logic [12:0] gsum;

  always_comb begin
    s2_next = '0;
    g1      = '0;
    g2      = '0;
    if (BAYER_ORDER == 0) begin
      g1        = s1.tl;
      s2_next.r = s1.tr;
      s2_next.b = s1.bl;
      g2        = s1.br;
    end else begin
      s2_next.r = s1.tl;
      g1        = s1.tr;
      g2        = s1.bl;
      s2_next.b = s1.br;
    end
    gsum      = {1'b0, g1} + {1'b0, g2};
    s2_next.g = gsum[12:1];
    s2_next.x = s1.x;
    s2_next.y = s1.y;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oRed    <= '0;
      oGreen  <= '0;
      oBlue   <= '0;
      oX_Cont <= '0;
      oY_Cont <= '0;
    end else if (vld_pipe[1]) begin
      oRed    <= s2.r;
      oGreen  <= s2.g;
      oBlue   <= s2.b;
      oX_Cont <= s2.x;
      oY_Cont <= s2.y;
    end
  end

  assign oDval = vld_pipe[STAGES];

endmodule

// File: tb/tb_bayer_quad_demosaic.sv
// Randomised and directed stimulus against a quad-level reference model; two DUTs
// cover GRBG with a wide line and RGGB with a 4-pixel line.
module tb_bayer_quad_demosaic;
  localparam int LW0 = 8;
  localparam int LW1 = 4;

  logic        iClk, iRst_n, iDval, iFval;
  logic [11:0] iData;
  logic [15:0] iX_Cont, iY_Cont;
  logic [11:0] o_r [2], o_g [2], o_b [2];
  logic        o_dv [2];
  logic [15:0] o_x [2], o_y [2];

  bayer_quad_demosaic #(.LINE_WIDTH(LW0), .BAYER_ORDER(0)) dut_a (
    .iClk(iClk), .iRst_n(iRst_n), .iData(iData), .iDval(iDval),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iFval(iFval),
    .oRed(o_r[0]), .oGreen(o_g[0]), .oBlue(o_b[0]), .oDval(o_dv[0]),
    .oX_Cont(o_x[0]), .oY_Cont(o_y[0]));

  bayer_quad_demosaic #(.LINE_WIDTH(LW1), .BAYER_ORDER(1)) dut_b (
    .iClk(iClk), .iRst_n(iRst_n), .iData(iData), .iDval(iDval),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont), .iFval(iFval),
    .oRed(o_r[1]), .oGreen(o_g[1]), .oBlue(o_b[1]), .oDval(o_dv[1]),
    .oX_Cont(o_x[1]), .oY_Cont(o_y[1]));

  initial begin
    iClk = 0;
    forever #5 iClk = ~iClk;
  end

  typedef struct {
    int due;
    int r, g, b, x, y;
  } exp_t;

  exp_t q0[$], q1[$], plog0[$], plog1[$];
  exp_t last [2];
  int   lb [2][16];
  int   hold [2];
  int   comp_cyc[$];
  int   cyc, total, bad;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic exp_t quad(input int ord, input int tl, input int tr,
                                input int bl, input int br, input int x, input int y);
    exp_t e;
    int g1, g2;
    if (ord == 0) begin g1 = tl; e.r = tr; e.b = bl; g2 = br; end
    else          begin e.r = tl; g1 = tr; g2 = bl; e.b = br; end
    e.g = (g1 + g2) / 2;
    e.x = x; e.y = y; e.due = 0;
    return e;
  endfunction

  // Reference behaviour at one accepting clock edge.
  task automatic model_edge();
    int d, x, y;
    d = int'(iData); x = int'(iX_Cont); y = int'(iY_Cont);
    for (int k = 0; k < 2; k++) begin
      int lw;
      exp_t e;
      lw = (k == 0) ? LW0 : LW1;
      if (iFval && iDval && x < lw) begin
        if (y % 2 == 0)      lb[k][x] = d;
        else if (x % 2 == 0) hold[k] = d;
        else begin
          e = quad(k, lb[k][x-1], lb[k][x], hold[k], d, x / 2, y / 2);
          e.due = cyc + 2;
          if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
      end
      if (!iFval) hold[k] = 0;
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      bit   pulse;
      pulse = 0;
      if (k == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); pulse = 1; end
      if (k == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); pulse = 1; end
      if (pulse) begin
        last[k] = e;
        if (k == 0) plog0.push_back(e); else plog1.push_back(e);
      end
      chk($sformatf("dval[%0d]", k), int'(o_dv[k]), int'(pulse));
      chk($sformatf("red[%0d]", k), int'(o_r[k]), last[k].r);
      chk($sformatf("green[%0d]", k), int'(o_g[k]), last[k].g);
      chk($sformatf("blue[%0d]", k), int'(o_b[k]), last[k].b);
      chk($sformatf("x[%0d]", k), int'(o_x[k]), last[k].x);
      chk($sformatf("y[%0d]", k), int'(o_y[k]), last[k].y);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    cyc++;
    if (iRst_n) model_edge();
    @(negedge iClk);
    compare();
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++) begin
      last[k] = '{default: 0};
      hold[k] = 0;
    end
  endtask

  task automatic async_reset(input int cycles);
    iRst_n = 0;
    iDval  = 0;
    #1;
    model_reset();
    compare();
    repeat (cycles) tick();
    iRst_n = 1;
  endtask

  task automatic px(input int d, input int x, input int y, input int gaps);
    iData = 12'(d); iX_Cont = 16'(x); iY_Cont = 16'(y); iDval = 1; iFval = 1;
    tick();
    if (y % 2 == 1 && x % 2 == 1) comp_cyc.push_back(cyc);
    repeat (gaps) begin
      iDval = 0; iData = 12'($urandom);
      tick();
    end
    iDval = 0;
  endtask

  task automatic idle(input int n);
    iFval = 0; iDval = 0;
    repeat (n) tick();
  endtask

  task automatic frame2(input int r0[4], input int r1[4], input int gaps);
    for (int x = 0; x < 4; x++) px(r0[x], x, 0, gaps);
    for (int x = 0; x < 4; x++) px(r1[x], x, 1, gaps);
    idle(4);
  endtask

  task automatic clear_logs();
    plog0.delete(); plog1.delete(); comp_cyc.delete();
  endtask

  int row0[4] = '{100, 200, 101, 201};
  int row1[4] = '{300, 400, 301, 401};
  int ga[4]   = '{4095, 7, 4095, 9};
  int gb[4]   = '{11, 4095, 13, 0};

  initial begin
    total = 0; bad = 0; cyc = 0;
    iRst_n = 1; iDval = 0; iFval = 0; iData = 0; iX_Cont = 0; iY_Cont = 0;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 16; i++) lb[k][i] = 0;
    @(negedge iClk);
    async_reset(3);
    chk("reset_dval", int'(o_dv[0]), 0);
    chk("reset_red", int'(o_r[0]), 0);
    idle(2);

    // Basic quads, both Bayer orders, back-to-back input.
    clear_logs();
    frame2(row0, row1, 0);
    chk("t1_count", plog0.size(), 2);
    if (plog0.size() == 2) begin
      chk("t1_q0_r", plog0[0].r, 200); chk("t1_q0_g", plog0[0].g, 250);
      chk("t1_q0_b", plog0[0].b, 300); chk("t1_q0_x", plog0[0].x, 0);
      chk("t1_q1_r", plog0[1].r, 201); chk("t1_q1_g", plog0[1].g, 251);
      chk("t1_q1_b", plog0[1].b, 301); chk("t1_q1_x", plog0[1].x, 1);
      chk("t1_latency", plog0[0].due - comp_cyc[0], 2);
    end
    chk("t2_count", plog1.size(), 2);
    if (plog1.size() > 0) begin
      chk("t2_r", plog1[0].r, 100); chk("t2_g", plog1[0].g, 250); chk("t2_b", plog1[0].b, 400);
    end

    // Green extremes.
    clear_logs();
    frame2(ga, gb, 0);
    if (plog0.size() == 2) begin
      chk("t3_g_max", plog0[0].g, 4095);
      chk("t3_g_half", plog0[1].g, 2047);
    end else chk("t3_count", plog0.size(), 2);

    // Idle gaps between samples.
    clear_logs();
    frame2(row0, row1, 3);
    chk("t4_count", plog0.size(), 2);
    if (plog0.size() == 2) begin
      chk("t4_q1_g", plog0[1].g, 251);
      chk("t4_latency", plog0[1].due - comp_cyc[1], 2);
    end

    // iFval drops right after a completing sample, then a frame starting on an odd row.
    clear_logs();
    for (int x = 0; x < 4; x++) px(row0[x], x, 0, 0);
    px(300, 0, 1, 0);
    px(400, 1, 1, 0);
    idle(5);
    chk("t5_drop_count", plog0.size(), 1);
    clear_logs();
    px(500, 0, 1, 0); px(600, 1, 1, 0); px(501, 2, 1, 0); px(601, 3, 1, 0);
    idle(4);
    chk("t5_stale_count", plog0.size(), 2);
    if (plog0.size() > 0) begin
      chk("t5_stale_r", plog0[0].r, 200); chk("t5_stale_g", plog0[0].g, 350);
      chk("t5_stale_b", plog0[0].b, 500);
    end

    // Reset between a completing sample and its output.
    clear_logs();
    for (int x = 0; x < 4; x++) px(row0[x], x, 0, 0);
    px(300, 0, 1, 0);
    px(400, 1, 1, 0);
    async_reset(2);
    chk("t6_rst_dval", int'(o_dv[0]), 0);
    idle(6);
    chk("t6_rst_count", plog0.size(), 0);

    // Wide frame: columns beyond the 4-pixel line are ignored.
    clear_logs();
    for (int y = 0; y < 2; y++) for (int x = 0; x < 8; x++) px(int'($urandom_range(0, 4095)), x, y, 0);
    idle(4);
    chk("t6_wide_a", plog0.size(), 4);
    chk("t6_wide_b", plog1.size(), 2);

    // Randomised frames with gaps, early frame ends and occasional resets.
    for (int f = 0; f < 40; f++) begin
      int h;
      bit cut;
      h = int'($urandom_range(2, 5));
      cut = 0;
      for (int y = 0; y < h && !cut; y++)
        for (int x = 0; x < 10 && !cut; x++) begin
          px(int'($urandom_range(0, 4095)), x, y, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
          if ($urandom_range(0, 60) == 0) cut = 1;
        end
      if ($urandom_range(0, 9) == 0) async_reset(int'($urandom_range(1, 3)));
      idle(int'($urandom_range(1, 4)));
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
